// File: rtl/mux_input_conditioner.sv
// mux_input_conditioner: synchronizes and debounces the select and data pads
// that feed the 2:1 mux tile, and flags every select transition with a pulse.
// Optional feature: define MUX_COND_TOGGLE_EN to build the toggle select mode.
// Without it the mode pad is ignored and s_out always follows the debounced select.
module mux_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic sel_raw,
  input  logic i0_raw,
  input  logic i1_raw,
  input  logic mode,
  output logic s_out,
  output logic i0_out,
  output logic i1_out,
  output logic sel_change
);

  // Terminal count: a mismatch seen with the counter here is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Channel index: 0 = sel, 1 = i0, 2 = i1.
  logic [2:0]       sync1_d, sync1_q;
  logic [2:0]       sync2_d, sync2_q;
  logic [2:0]       deb_d, deb_q;
  logic [CNT_W-1:0] cnt_d [3];
  logic [CNT_W-1:0] cnt_q [3];
  logic             s_d, s_q;
  logic             sel_change_d, sel_change_q;
  logic             toggle_mode;

`ifdef MUX_COND_TOGGLE_EN
  logic mode_sync1_d, mode_sync1_q;
  logic mode_sync2_d, mode_sync2_q;

  // Mode is quasi-static, so it is only synchronized, never debounced.
  always_comb begin
    mode_sync1_d = mode;
    mode_sync2_d = mode_sync1_q;
  end

  // Two-flop synchronizer for the mode pad.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_sync1_q <= 1'b0;
      mode_sync2_q <= 1'b0;
    end else begin
      mode_sync1_q <= mode_sync1_d;
      mode_sync2_q <= mode_sync2_d;
    end
  end

  assign toggle_mode = mode_sync2_q;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign toggle_mode = 1'b0;
`endif

  // Synchronizer inputs and per-channel debounce: a level is accepted only
  // after it differs from the debounced value for DEBOUNCE_CYCLES evaluations.
  always_comb begin
    sync1_d = {i1_raw, i0_raw, sel_raw};
    sync2_d = sync1_q;
    deb_d   = deb_q;
    for (int c = 0; c < 3; c++) begin
      cnt_d[c] = '0;
      if (sync2_q[c] != deb_q[c]) begin
        if (cnt_q[c] == CNT_LAST) begin
          deb_d[c] = sync2_q[c];
        end else begin
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
        end
      end
    end
  end

  // Select output: level mode follows the next debounced select; toggle mode
  // flips only on a debounced rising edge. The change pulse is registered so
  // it lines up with the first cycle s_out shows its new value.
  always_comb begin
    s_d = deb_d[0];
    if (toggle_mode) begin
      s_d = s_q;
      if (deb_d[0] && !deb_q[0]) begin
        s_d = ~s_q;
      end
    end
    sel_change_d = s_d ^ s_q;
  end

  // All conditioning state; reset drops every output immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      deb_q        <= '0;
      cnt_q[0]     <= '0;
      cnt_q[1]     <= '0;
      cnt_q[2]     <= '0;
      s_q          <= 1'b0;
      sel_change_q <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      deb_q        <= deb_d;
      cnt_q[0]     <= cnt_d[0];
      cnt_q[1]     <= cnt_d[1];
      cnt_q[2]     <= cnt_d[2];
      s_q          <= s_d;
      sel_change_q <= sel_change_d;
    end
  end

  assign s_out      = s_q;
  assign i0_out     = deb_q[1];
  assign i1_out     = deb_q[2];
  assign sel_change = sel_change_q;

endmodule

// File: tb/tb_mux_input_conditioner.sv
// Directed bench for mux_input_conditioner with DEBOUNCE_CYCLES = 4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mux_input_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel_raw = 1'b0;
  logic i0_raw = 1'b0;
  logic i1_raw = 1'b0;
  logic mode = 1'b0;
  logic s_out, i0_out, i1_out, sel_change;

  int n_cmp = 0;
  int n_err = 0;

  mux_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .sel_raw(sel_raw), .i0_raw(i0_raw), .i1_raw(i1_raw),
    .mode(mode), .s_out(s_out), .i0_out(i0_out), .i1_out(i1_out),
    .sel_change(sel_change)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset with all raw inputs low, then release; leaves a clean idle state.
  task automatic clean_reset();
    sel_raw = 1'b0; i0_raw = 1'b0; i1_raw = 1'b0;
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(2);
  endtask

  int pulses;
  int highs;

  initial begin
    // Reset behaviour: raw inputs high while reset is held.
    sel_raw = 1'b1; i0_raw = 1'b1; i1_raw = 1'b1; mode = 1'b0;
    step(2);
    #1;
    check_eq("rst_s_out", s_out, 0);
    check_eq("rst_i0_out", i0_out, 0);
    check_eq("rst_i1_out", i1_out, 0);
    check_eq("rst_sel_change", sel_change, 0);
    @(negedge clk);
    rst = 1'b0;
    step(5);                               // edges 0..4
    check_eq("post_rst_i0_edge4", i0_out, 0);
    step(1);                               // edge 5 = 1 + DEBOUNCE_CYCLES
    check_eq("post_rst_i0_edge5", i0_out, 1);
    check_eq("post_rst_i1_edge5", i1_out, 1);
    check_eq("post_rst_s_edge5", s_out, 1);
    check_eq("post_rst_selchg_pulse", sel_change, 1);
    step(1);
    check_eq("post_rst_selchg_end", sel_change, 0);

    // Asynchronous reset drops outputs immediately, mid-cycle, without a pulse.
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_s_out", s_out, 0);
    check_eq("async_rst_i0_out", i0_out, 0);
    check_eq("async_rst_selchg", sel_change, 0);
    clean_reset();

    // Latency on i1.
    i1_raw = 1'b1;
    step(5);
    check_eq("lat_i1_edge4", i1_out, 0);
    step(1);
    check_eq("lat_i1_edge5", i1_out, 1);
    check_eq("lat_s_unchanged", s_out, 0);
    check_eq("lat_i0_unchanged", i0_out, 0);
    clean_reset();

    // Bounce rejection on select: 1,1,0,1,1,1,0 then hold 0.
    begin
      logic [6:0] pat;
      pat = 7'b1101110;
      highs = 0;
      for (int i = 0; i < 16; i++) begin
        sel_raw = (i < 7) ? pat[6 - i] : 1'b0;
        step(1);
        if (sel_change) highs++;
        if (s_out) highs++;
      end
      check_eq("bounce_s_out", s_out, 0);
      check_eq("bounce_activity", highs, 0);
    end
    clean_reset();

    // Mid-count reset on i0: count lost, full latency afterwards.
    i0_raw = 1'b1;
    step(3);                               // edges 0..2; terminal would be edge 5
    rst = 1'b1;
    #1;
    check_eq("midcnt_rst_i0", i0_out, 0);
    step(2);
    rst = 1'b0;
    step(5);
    check_eq("midcnt_i0_edge4", i0_out, 0);
    step(1);
    check_eq("midcnt_i0_edge5", i0_out, 1);
    check_eq("midcnt_selchg", sel_change, 0);
    clean_reset();

`ifdef MUX_COND_TOGGLE_EN
    // Toggle mode: two presses of 10 high / 10 low cycles.
    mode = 1'b1;
    step(3);
    pulses = 0;
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      sel_raw = (i < 10) || (i >= 20 && i < 30);
      step(1);
      if (sel_change) highs++;
      if (i == 4)  check_eq("tog_before_press1", s_out, 0);
      if (i == 5)  check_eq("tog_press1", s_out, 1);
      if (i == 5)  check_eq("tog_press1_pulse", sel_change, 1);
      if (i == 6)  check_eq("tog_press1_pulse_end", sel_change, 0);
      if (i == 16) check_eq("tog_release1_hold", s_out, 1);
      if (i == 25) check_eq("tog_press2", s_out, 0);
      if (i == 39) check_eq("tog_release2_hold", s_out, 0);
    end
    check_eq("tog_pulse_cycles", highs, 2);

    // Third press leaves s_out=1 with deb_sel=0, then switch back to level.
    for (int i = 0; i < 20; i++) begin
      sel_raw = (i < 10);
      step(1);
    end
    check_eq("tog_press3", s_out, 1);
    mode = 1'b0;
    step(2);
    check_eq("modesw_hold_edge1", s_out, 1);
    check_eq("modesw_no_pulse_yet", sel_change, 0);
    step(1);
    check_eq("modesw_s_edge2", s_out, 0);
    check_eq("modesw_pulse", sel_change, 1);
    step(1);
    check_eq("modesw_pulse_end", sel_change, 0);
`else
    // Without the toggle build, mode is ignored: select follows level.
    mode = 1'b1;
    step(3);
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      sel_raw = (i < 10);
      step(1);
      if (sel_change) highs++;
      if (i == 4)  check_eq("lvl_before_press", s_out, 0);
      if (i == 5)  check_eq("lvl_press", s_out, 1);
      if (i == 14) check_eq("lvl_before_release", s_out, 1);
      if (i == 15) check_eq("lvl_release", s_out, 0);
      if (i == 15) check_eq("lvl_release_pulse", sel_change, 1);
    end
    check_eq("lvl_pulse_cycles", highs, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
